wb_macro_splitter: RTL and testbench
====================================

// Module: wb_macro_splitter
// PURPOSE
//  Wishbone 1:N splitter between the user_project_wrapper slave port (wbs_*) and N macro slaves.
//  Decodes wbs_adr_i into one slot and forwards one transaction at a time to that slot's macro.
//  Returns exactly one wbs_ack_o and one wbs_dat_o upstream, so macros never contend on the bus.
//  Gates each slot with its LA 'active' bit; bounds every transaction with a timeout.
// PARAMETERS
//  N_SLV      4             number of downstream macro slots (2..8)
//  BASE_ADDR  32'h3000_0000 base of the user Wishbone window
//  WIN_BITS   20            log2 of total window size; adr[31:WIN_BITS] must equal BASE_ADDR[31:WIN_BITS]
//  SLOT_LSB   16            slot index = adr[SLOT_LSB +: $clog2(N_SLV)]
//  TIMEOUT    255           cycles waited in FWD before abort (8-bit counter, 1..255)
//  ERR_DATA   32'hBADC_0FFE read data returned on decode error or timeout
// PORTS
//  wb_clk_i        in   1        Wishbone clock
//  wb_rst_ni       in   1        asynchronous reset, active-low
//  wbs_cyc_i       in   1        upstream cycle
//  wbs_stb_i       in   1        upstream strobe
//  wbs_we_i        in   1        upstream write enable
//  wbs_sel_i       in   4        upstream byte selects
//  wbs_adr_i       in   32       upstream address
//  wbs_dat_i       in   32       upstream write data
//  wbs_ack_o       out  1        upstream ack, single-cycle pulse
//  wbs_dat_o       out  32       upstream read data, valid while wbs_ack_o=1
//  active_i        in   N_SLV    per-slot enable, sourced from la_data_in[N_SLV:1]
//  s_cyc_o         out  N_SLV    one-hot downstream cycle
//  s_stb_o         out  N_SLV    one-hot downstream strobe
//  s_we_o          out  1        shared downstream write enable
//  s_sel_o         out  4        shared downstream byte selects
//  s_adr_o         out  32       shared downstream address
//  s_dat_o         out  32       shared downstream write data
//  s_ack_i         in   N_SLV    per-slot ack
//  s_dat_i         in   32*N_SLV per-slot read data; slot k at [32k +: 32]
//  err_irq_o       out  1        one-cycle pulse on any decode error or timeout
//  err_status_o    out  2        sticky last error: 0=none, 1=bad window/slot, 2=inactive slot, 3=timeout
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. Timeout counter=0. err_status_o=0.
//  FSM IDLE:
//   - on wbs_cyc_i&wbs_stb_i, latch adr/dat/sel/we and slot index.
//   - window mismatch or slot>=N_SLV -> ERR, status 1.
//   - active_i[slot]=0 -> ERR, status 2.
//   - otherwise -> FWD.
//  FSM FWD:
//   - s_cyc_o[slot]=s_stb_o[slot]=1 (registered; first visible the cycle after IDLE accept).
//   - counter increments each cycle.
//   - s_ack_i[slot]=1 -> capture s_dat_i slot; drop s_cyc/s_stb same edge; -> RESP.
//   - counter==TIMEOUT with no ack -> drop strobe; -> ERR, status 3.
//  FSM RESP: wbs_ack_o=1 and wbs_dat_o=captured data for exactly 1 cycle -> IDLE.
//  FSM ERR:
//   - wbs_ack_o=1 and wbs_dat_o=ERR_DATA for 1 cycle; err_irq_o=1 that cycle.
//   - writes are discarded but still acked.
//   - -> IDLE.
//  Latency:
//   - slave acking in its first strobe cycle -> wbs_ack_o 2 cycles after IDLE accept.
//   - decode error -> 1 cycle after accept.
//  wbs_dat_o reads 0 whenever wbs_ack_o=0.
//  IDLE also requires wbs_ack_o=0 on the prior cycle, so a held stb is never re-accepted.
//  Acks from unselected slots, and late acks arriving in IDLE/RESP/ERR, are ignored.
//  wbs_cyc_i dropping during FWD: drop slave strobe next edge, -> IDLE, no upstream ack, no error.
//  active_i falling during FWD does not abort; it is sampled only at accept.
//  Async reset mid-transaction: strobes and ack drop immediately; no response is issued.
//  err_status_o is overwritten by each new error; it is cleared only by reset.
// STRUCTURE
//  wb_split_pkg:
//   - state enum {IDLE,FWD,RESP,ERR}.
//   - error codes ERR_NONE/ERR_DECODE/ERR_INACTIVE/ERR_TIMEOUT.
//   - ERR_DATA default.
//  Sub-module wb_split_decode (combinational):
//   - adr + active_i -> slot index, hit, error code.
//  The FSM, counter and capture registers stay in the top.
// TESTING
//  1. Read slot 2 (adr 3002_0010, active=4'b1111); slave acks in 1st cycle with 1234_5678
//     -> wbs_ack_o 2 cycles after accept, dat=1234_5678.
//  2. Write slot 0 (adr 3000_0004, dat A5A5_A5A5, sel 4'b0011)
//     -> s_stb_o=4'b0001, s_dat_o/s_sel_o match; single upstream ack.
//  3. Read adr 3004_0000 (slot 4 with N_SLV=4) or 4000_0000
//     -> ack 1 cycle after accept, dat=BADC_0FFE, err_irq pulse, err_status=1.
//  4. active=4'b1101, access slot 1 -> no s_stb_o ever; ERR_DATA; err_status=2.
//  5. Slot 3 never acks -> s_stb_o[3] high exactly 255 cycles; ERR_DATA ack; err_status=3.
//     A later s_ack_i[3] pulse is ignored.
//  6. Drop wbs_cyc_i 3 cycles into FWD -> no wbs_ack_o.
//     Assert wb_rst_ni=0 mid-FWD -> all outputs 0 asynchronously; next read succeeds.

Source files
------------

// File: rtl/wb_split_pkg.sv
// Shared types and constants for the Wishbone 1:N macro splitter.
//   state_t    : transaction FSM states
//   err_code_t : error status codes, also the encoding of err_status_o
//   ERR_DATA_DEFAULT : read data returned upstream on any error
package wb_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_RESP,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_DECODE   = 2'd1,
        ERR_INACTIVE = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADC_0FFE;

endpackage

// File: rtl/wb_split_decode.sv
// Combinational address decoder for the Wishbone splitter.
//   adr      : upstream address
//   active   : per-slot enable bits
//   slot     : decoded slot index
//   hit      : address maps to an existing, active slot
//   err_code : ERR_DECODE (window/slot range), ERR_INACTIVE, or ERR_NONE
module wb_split_decode
    import wb_split_pkg::*;
#(
    parameter int unsigned N_SLV     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned WIN_BITS  = 20,
    parameter int unsigned SLOT_LSB  = 16,
    parameter int unsigned SLOT_W    = $clog2(N_SLV)
) (
    input  logic [31:0]       adr,
    input  logic [N_SLV-1:0]  active,
    output logic [SLOT_W-1:0] slot,
    output logic              hit,
    output err_code_t         err_code
);

    localparam int unsigned FIELD_W = WIN_BITS - SLOT_LSB;

    // The whole slot field inside the window is range-checked, so an
    // address above the last populated slot is a decode error rather
    // than aliasing back onto a low slot.
    logic [FIELD_W-1:0] field;
    logic               win_ok;
    logic               range_ok;

    always_comb begin
        field    = adr[WIN_BITS-1:SLOT_LSB];
        win_ok   = (adr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
        range_ok = ({{(32-FIELD_W){1'b0}}, field} < N_SLV);
        slot     = field[SLOT_W-1:0];
        hit      = 1'b0;
        err_code = ERR_NONE;
        if (!win_ok || !range_ok) begin
            err_code = ERR_DECODE;
        end else if (!active[slot]) begin
            err_code = ERR_INACTIVE;
        end else begin
            hit = 1'b1;
        end
    end

    logic unused_adr_bits;
    assign unused_adr_bits = ^adr[SLOT_LSB-1:0];

endmodule

// File: rtl/wb_macro_splitter.sv
// Wishbone 1:N splitter between the user-project slave port and N macros.
// One transaction at a time is forwarded to the decoded slot; exactly one
// upstream ack is returned per accepted transaction (or none if the
// master abandons the cycle). Errors answer with ERR_DATA and pulse
// err_irq_o; err_status_o holds the most recent error code.
//   wb_clk_i, wb_rst_ni        : clock, async active-low reset
//   wbs_*                      : upstream Wishbone slave port
//   active_i                   : per-slot enable, sampled at accept
//   s_cyc_o/s_stb_o            : one-hot downstream cycle/strobe
//   s_we_o/s_sel_o/s_adr_o/s_dat_o : shared downstream request fields
//   s_ack_i/s_dat_i            : per-slot ack and read data (slot k at [32k +: 32])
//   err_irq_o, err_status_o    : error pulse and sticky last error code
module wb_macro_splitter
    import wb_split_pkg::*;
#(
    parameter int unsigned N_SLV     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned WIN_BITS  = 20,
    parameter int unsigned SLOT_LSB  = 16,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [N_SLV-1:0]    active_i,
    output logic [N_SLV-1:0]    s_cyc_o,
    output logic [N_SLV-1:0]    s_stb_o,
    output logic                s_we_o,
    output logic [3:0]          s_sel_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    input  logic [N_SLV-1:0]    s_ack_i,
    input  logic [32*N_SLV-1:0] s_dat_i,
    output logic                err_irq_o,
    output logic [1:0]          err_status_o
);

    localparam int unsigned SLOT_W = $clog2(N_SLV);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [SLOT_W-1:0] slot_q, dec_slot;
    logic        dec_hit;
    err_code_t   dec_err, err_code_d;
    logic        latch, capture, err_set;
    logic        ack_prev_q;
    logic [31:0] adr_q, dat_q, rdat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    err_code_t   err_status_q;
    logic [N_SLV-1:0] onehot;

    wb_split_decode #(
        .N_SLV    (N_SLV),
        .BASE_ADDR(BASE_ADDR),
        .WIN_BITS (WIN_BITS),
        .SLOT_LSB (SLOT_LSB),
        .SLOT_W   (SLOT_W)
    ) u_decode (
        .adr     (wbs_adr_i),
        .active  (active_i),
        .slot    (dec_slot),
        .hit     (dec_hit),
        .err_code(dec_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + 8'd1;
        err_code_d = ERR_NONE;
        latch      = 1'b0;
        capture    = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ack_prev_q blocks re-accepting a strobe still held from the last ack.
                if (wbs_cyc_i && wbs_stb_i && !ack_prev_q) begin
                    latch = 1'b1;
                    cnt_d = '0;
                    if (dec_hit) begin
                        state_d = ST_FWD;
                    end else begin
                        state_d    = ST_ERR;
                        err_set    = 1'b1;
                        err_code_d = dec_err;
                    end
                end
            end
            ST_FWD: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (s_ack_i[slot_q]) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_inc == 8'(TIMEOUT)) begin
                    state_d    = ST_ERR;
                    err_set    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            slot_q       <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            rdat_q       <= '0;
            err_status_q <= ERR_NONE;
            ack_prev_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_prev_q <= wbs_ack_o;
            if (latch) begin
                slot_q <= dec_slot;
                adr_q  <= wbs_adr_i;
                dat_q  <= wbs_dat_i;
                sel_q  <= wbs_sel_i;
                we_q   <= wbs_we_i;
            end
            if (capture) begin
                rdat_q <= s_dat_i[{slot_q, 5'b0} +: 32];
            end
            if (err_set) begin
                err_status_q <= err_code_d;
            end
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        onehot = '0;
        if (state_q == ST_FWD) begin
            onehot[slot_q] = 1'b1;
        end
    end

    assign s_cyc_o      = onehot;
    assign s_stb_o      = onehot;
    assign s_we_o       = we_q;
    assign s_sel_o      = sel_q;
    assign s_adr_o      = adr_q;
    assign s_dat_o      = dat_q;
    assign wbs_ack_o    = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign wbs_dat_o    = (state_q == ST_RESP) ? rdat_q :
                          (state_q == ST_ERR)  ? ERR_DATA : '0;
    assign err_irq_o    = (state_q == ST_ERR);
    assign err_status_o = err_status_q;

endmodule

// File: tb/tb_wb_macro_splitter.sv
module tb_wb_macro_splitter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic          ack;
    logic [31:0]   rdat;
    logic [N-1:0]  active, s_cyc, s_stb, s_ack;
    logic          s_we;
    logic [3:0]    s_sel;
    logic [31:0]   s_adr, s_dat;
    logic [32*N-1:0] s_dat_in;
    logic          irq;
    logic [1:0]    err_status;

    logic [N-1:0]  slave_en, ack_force;
    logic [31:0]   slv_dat [N];

    // Slave model: combinational ack in the first strobe cycle when enabled.
    assign s_ack    = (s_stb & slave_en) | ack_force;
    assign s_dat_in = {slv_dat[3], slv_dat[2], slv_dat[1], slv_dat[0]};

    wb_macro_splitter #(
        .N_SLV    (N),
        .BASE_ADDR(32'h3000_0000),
        .WIN_BITS (20),
        .SLOT_LSB (16),
        .TIMEOUT  (255),
        .ERR_DATA (32'hBADC_0FFE)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .active_i    (active),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_we_o      (s_we),
        .s_sel_o     (s_sel),
        .s_adr_o     (s_adr),
        .s_dat_o     (s_dat),
        .s_ack_i     (s_ack),
        .s_dat_i     (s_dat_in),
        .err_irq_o   (irq),
        .err_status_o(err_status)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: {irq, data} expected on each upstream ack.
    logic [32:0] sb_q [$];
    logic [32:0] sb_e;

    logic [N-1:0] exp_stb;
    logic [31:0]  exp_adr, exp_wdat;
    logic [3:0]   exp_sel;
    logic         exp_we;
    int           stb_cnt [N];
    int           irq_cnt = 0;
    logic         stb_prev = 1'b0;

    initial for (int i = 0; i < N; i++) stb_cnt[i] = 0;

    always @(negedge clk) begin
        if (ack) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_ack", 32'(ack), 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_eq("ack_data", rdat, sb_e[31:0]);
                check_eq("ack_irq", 32'(irq), 32'(sb_e[32]));
            end
        end
        if (irq) irq_cnt++;
        for (int i = 0; i < N; i++) if (s_stb[i]) stb_cnt[i]++;
        if ((s_stb != '0) && !stb_prev) begin
            check_eq("stb_onehot", 32'(s_stb), 32'(exp_stb));
            check_eq("cyc_onehot", 32'(s_cyc), 32'(exp_stb));
            check_eq("s_adr", s_adr, exp_adr);
            check_eq("s_dat", s_dat, exp_wdat);
            check_eq("s_sel", 32'(s_sel), 32'(exp_sel));
            check_eq("s_we", 32'(s_we), 32'(exp_we));
        end
        stb_prev = (s_stb != '0);
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        exp_stb  = 4'b0001 << a[17:16];
        exp_adr  = a;
        exp_wdat = d;
        exp_sel  = s;
        exp_we   = w;
        @(posedge clk); #1;
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w, input int exp_lat,
                           input logic [31:0] exp_dat, input logic exp_irq);
        int  lat;
        bit  got;
        sb_q.push_back({exp_irq, exp_dat});
        drive(a, d, s, w);
        @(negedge clk);
        check_eq({tag, "_accept_ack"}, 32'(ack), 32'd0);
        check_eq({tag, "_accept_dat"}, rdat, 32'd0);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 300 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                lat = i;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        // Strobe stays up across the edge after the ack; it must not be re-accepted.
        @(posedge clk);
        @(posedge clk); #1;
        release_bus();
    endtask

    int base;

    initial begin
        cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
        active = 4'b1111; slave_en = 4'b1111; ack_force = '0;
        slv_dat[0] = 32'h0BAD_F00D; slv_dat[1] = 32'h1111_1111;
        slv_dat[2] = 32'h1234_5678; slv_dat[3] = 32'h3333_3333;
        exp_stb = '0; exp_adr = '0; exp_wdat = '0; exp_sel = '0; exp_we = 0;

        repeat (3) @(negedge clk);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_dat", rdat, 32'd0);
        check_eq("rst_stb", 32'(s_stb), 32'd0);
        check_eq("rst_cyc", 32'(s_cyc), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_status", 32'(err_status), 32'd0);
        check_eq("rst_adr", s_adr, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("rd_slot2", 32'h3002_0010, 32'h0, 4'hF, 1'b0, 2, 32'h1234_5678, 1'b0);
        check_eq("rd_slot2_status", 32'(err_status), 32'd0);

        run_txn("wr_slot0", 32'h3000_0004, 32'hA5A5_A5A5, 4'b0011, 1'b1, 2, 32'h0BAD_F00D, 1'b0);

        run_txn("bad_slot", 32'h3004_0000, 32'h0, 4'hF, 1'b0, 1, 32'hBADC_0FFE, 1'b1);
        check_eq("bad_slot_status", 32'(err_status), 32'd1);
        run_txn("bad_win", 32'h4000_0000, 32'h0, 4'hF, 1'b0, 1, 32'hBADC_0FFE, 1'b1);
        check_eq("bad_win_status", 32'(err_status), 32'd1);

        active = 4'b1101;
        base = stb_cnt[1];
        run_txn("inactive", 32'h3001_0000, 32'h0, 4'hF, 1'b0, 1, 32'hBADC_0FFE, 1'b1);
        check_eq("inactive_status", 32'(err_status), 32'd2);
        check_eq("inactive_no_stb", 32'(stb_cnt[1] - base), 32'd0);
        active = 4'b1111;

        slave_en[3] = 1'b0;
        base = stb_cnt[3];
        run_txn("timeout", 32'h3003_0008, 32'h0, 4'hF, 1'b0, 256, 32'hBADC_0FFE, 1'b1);
        check_eq("timeout_stb_cycles", 32'(stb_cnt[3] - base), 32'd255);
        check_eq("timeout_status", 32'(err_status), 32'd3);
        @(posedge clk); #1 ack_force = 4'b1000;
        @(posedge clk); #1 ack_force = '0;
        repeat (3) @(negedge clk);
        check_eq("late_ack_status", 32'(err_status), 32'd3);
        slave_en[3] = 1'b1;

        // Master abandons the cycle while the slave is stalled.
        slave_en[0] = 1'b0;
        base = irq_cnt;
        drive(32'h3000_0020, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("abort_stb_up", 32'(s_stb), 32'b0001);
        @(posedge clk); #1;
        release_bus();
        repeat (5) @(negedge clk);
        check_eq("abort_stb_down", 32'(s_stb), 32'd0);
        check_eq("abort_no_irq", 32'(irq_cnt - base), 32'd0);
        check_eq("abort_status", 32'(err_status), 32'd3);
        slave_en[0] = 1'b1;

        // Asynchronous reset in the middle of a forward.
        slave_en[2] = 1'b0;
        drive(32'h3002_0000, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("midrst_stb_up", 32'(s_stb), 32'b0100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_stb", 32'(s_stb), 32'd0);
        check_eq("midrst_cyc", 32'(s_cyc), 32'd0);
        check_eq("midrst_ack", 32'(ack), 32'd0);
        check_eq("midrst_status", 32'(err_status), 32'd0);
        release_bus();
        @(negedge clk);
        rst_n = 1'b1;
        slave_en[2] = 1'b1;
        slv_dat[2] = 32'hCAFE_0002;
        repeat (2) @(negedge clk);
        run_txn("post_rst", 32'h3002_0040, 32'h0, 4'hF, 1'b0, 2, 32'hCAFE_0002, 1'b0);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("irq_total", 32'(irq_cnt), 32'd4);
        check_eq("final_status", 32'(err_status), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
